draw_sequencer: RTL and testbench

//  Frame-redraw scheduler for the snake game: on a start pulse from control, it sequences the

---
 rtl/snake_pkg.sv | 25 ++
 rtl/raster_scan.sv | 41 ++++
 rtl/draw_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_draw_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game: screen geometry, colours and the
// draw-sequencer state encoding (also mirrored on LEDR for debug).
package snake_pkg;

  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;
  localparam int WALL_W  = 4;
  localparam int MAX_SEG = 128;

  // Colours are {R,G,B}
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WALL  = 3'b111;
  localparam logic [2:0] COL_APPLE = 3'b100;
  localparam logic [2:0] COL_BODY  = 3'b010;
  localparam logic [2:0] COL_HEAD  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_APPLE = 3'd2,
    ST_SNAKE = 3'd3,
    ST_DONE  = 3'd4
  } draw_state_t;

endpackage

// File: rtl/raster_scan.sv
// Raster (cx,cy) walker: x fastest, wraps to (0,0) after the last pixel.
// Reusable for any full-screen pass (clear, menu, score screens).
module raster_scan #(
  parameter int W = 160,
  parameter int H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [7:0] cx,
  output logic [6:0] cy,
  output logic       last_px
);

  localparam logic [7:0] X_LAST = 8'(W - 1);
  localparam logic [6:0] Y_LAST = 7'(H - 1);

  logic [7:0] cx_r;
  logic [6:0] cy_r;

  // Advance the raster position one pixel per enabled cycle
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cx_r <= 8'd0;
      cy_r <= 7'd0;
    end else if (en) begin
      if (cx_r == X_LAST) begin
        cx_r <= 8'd0;
        cy_r <= (cy_r == Y_LAST) ? 7'd0 : cy_r + 7'd1;
      end else begin
        cx_r <= cx_r + 8'd1;
      end
    end
  end

  assign cx      = cx_r;
  assign cy      = cy_r;
  assign last_px = (cx_r == X_LAST) && (cy_r == Y_LAST);

endmodule

// File: rtl/draw_sequencer.sv
// Frame-redraw scheduler: on start, drives the single VGA plot port through
// the clear+border, apple and snake passes at one pixel per cycle, then
// pulses done for one cycle.
module draw_sequencer
  import snake_pkg::*;
#(
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120,
  parameter int WALL_W  = 4,
  parameter int MAX_SEG = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] snake_size,
  input  logic [7:0] apple_x,
  input  logic [6:0] apple_y,
  output logic [6:0] seg_addr,
  input  logic [7:0] seg_x,
  input  logic [6:0] seg_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] WALL_X_LO = 8'(WALL_W);
  localparam logic [7:0] WALL_X_HI = 8'(SCR_W - WALL_W);
  localparam logic [6:0] WALL_Y_LO = 7'(WALL_W);
  localparam logic [6:0] WALL_Y_HI = 7'(SCR_H - WALL_W);
  localparam logic [7:0] SEG_LIMIT = 8'(MAX_SEG);

  draw_state_t state_r, next_state_s;

  logic [7:0] cx_s;
  logic [6:0] cy_s;
  logic       last_px_s;
  logic       scan_en_s;
  logic       scan_clr_s;

  // 8 bits so a count of 128 is representable without wrapping
  logic [7:0] seg_cnt_r;
  logic [7:0] seg_n_s;
  logic       seg_last_s;

  logic [7:0] pix_x_s;
  logic [6:0] pix_y_s;
  logic [2:0] pix_col_s;
  logic       pix_plot_s;
  logic       done_s;

  logic [7:0] x_r;
  logic [6:0] y_r;
  logic [2:0] colour_r;
  logic       plot_r;
  logic       busy_r;
  logic       done_r;

  function automatic logic is_wall(input logic [7:0] px, input logic [6:0] py);
    return (px < WALL_X_LO) || (px >= WALL_X_HI) ||
           (py < WALL_Y_LO) || (py >= WALL_Y_HI);
  endfunction

  raster_scan #(
    .W (SCR_W),
    .H (SCR_H)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .en      (scan_en_s),
    .clr     (scan_clr_s),
    .cx      (cx_s),
    .cy      (cy_s),
    .last_px (last_px_s)
  );

  // Raster is held at the origin while idle so every frame starts at (0,0)
  assign scan_clr_s = (state_r == ST_IDLE);
  assign scan_en_s  = (state_r == ST_CLEAR);

  assign seg_n_s    = (snake_size > SEG_LIMIT) ? SEG_LIMIT : snake_size;
  assign seg_last_s = ((seg_cnt_r + 8'd1) == seg_n_s);
  assign seg_addr   = (state_r == ST_SNAKE) ? seg_cnt_r[6:0] : 7'd0;

  // Draw-state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Segment index: counts up only while drawing the snake
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_cnt_r <= 8'd0;
    end else if (state_r == ST_SNAKE) begin
      seg_cnt_r <= seg_cnt_r + 8'd1;
    end else begin
      seg_cnt_r <= 8'd0;
    end
  end

  // Next-state and pixel selection for the current pass
  always_comb begin
    next_state_s = state_r;
    pix_x_s      = 8'd0;
    pix_y_s      = 7'd0;
    pix_col_s    = COL_BLACK;
    pix_plot_s   = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_CLEAR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        pix_plot_s = 1'b1;
        pix_x_s    = cx_s;
        pix_y_s    = cy_s;
        pix_col_s  = is_wall(cx_s, cy_s) ? COL_WALL : COL_BLACK;
        if (last_px_s) begin
          next_state_s = ST_APPLE;
        end else begin
          next_state_s = ST_CLEAR;
        end
      end
      ST_APPLE: begin
        pix_plot_s = 1'b1;
        pix_x_s    = apple_x;
        pix_y_s    = apple_y;
        pix_col_s  = COL_APPLE;
        if (seg_n_s == 8'd0) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SNAKE;
        end
      end
      ST_SNAKE: begin
        pix_plot_s = 1'b1;
        pix_x_s    = seg_x;
        pix_y_s    = seg_y;
        pix_col_s  = (seg_cnt_r == 8'd0) ? COL_HEAD : COL_BODY;
        if (seg_last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SNAKE;
        end
      end
      ST_DONE: begin
        done_s       = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Registered plot port, busy and done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r      <= 8'd0;
      y_r      <= 7'd0;
      colour_r <= 3'b000;
      plot_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      x_r      <= pix_x_s;
      y_r      <= pix_y_s;
      colour_r <= pix_col_s;
      plot_r   <= pix_plot_s;
      // Covers the cycle after acceptance through the done cycle
      busy_r   <= (next_state_s != ST_IDLE) || (state_r != ST_IDLE);
      done_r   <= done_s;
    end
  end

  assign x      = x_r;
  assign y      = y_r;
  assign colour = colour_r;
  assign plot   = plot_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: a behavioural model builds the
// expected plot list for each frame and every output cycle is compared.
module tb_draw_sequencer;

  localparam int W          = 160;
  localparam int H          = 120;
  localparam int WALL       = 4;
  localparam int SNAKE_BASE = W * H + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] snake_size;
  logic [7:0] apple_x;
  logic [6:0] apple_y;
  logic [6:0] seg_addr;
  logic [7:0] seg_x;
  logic [6:0] seg_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  logic [7:0] seg_mem_x [128];
  logic [6:0] seg_mem_y [128];

  logic [7:0] exp_x [$];
  logic [6:0] exp_y [$];
  logic [2:0] exp_c [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Snake segment store answers the indexed read in the same cycle
  assign seg_x = seg_mem_x[seg_addr];
  assign seg_y = seg_mem_y[seg_addr];

  draw_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .snake_size (snake_size),
    .apple_x    (apple_x),
    .apple_y    (apple_y),
    .seg_addr   (seg_addr),
    .seg_x      (seg_x),
    .seg_y      (seg_y),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected plot list for one frame, straight from the drawing rules
  task automatic build_expected(input int size, input int ax, input int ay);
    int n;
    exp_x.delete();
    exp_y.delete();
    exp_c.delete();
    for (int py = 0; py < H; py++) begin
      for (int px = 0; px < W; px++) begin
        exp_x.push_back(8'(px));
        exp_y.push_back(7'(py));
        if (px < WALL || px >= W - WALL || py < WALL || py >= H - WALL)
          exp_c.push_back(3'b111);
        else
          exp_c.push_back(3'b000);
      end
    end
    exp_x.push_back(8'(ax));
    exp_y.push_back(7'(ay));
    exp_c.push_back(3'b100);
    n = (size > 128) ? 128 : size;
    for (int j = 0; j < n; j++) begin
      exp_x.push_back(seg_mem_x[j]);
      exp_y.push_back(seg_mem_y[j]);
      exp_c.push_back((j == 0) ? 3'b110 : 3'b010);
    end
  endtask

  // Present start to an idle sequencer; returns #1 after the accepting edge
  task automatic launch(input bit hold);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Walk one frame from the accepting edge through done and one cycle beyond
  task automatic check_frame(input bit hold, input int pulse_at);
    int len;
    len = exp_x.size();
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    check_eq("plot_after_accept", 32'(plot), 32'd0);
    for (int c = 0; c <= len; c++) begin
      if (c >= SNAKE_BASE && c < len)
        check_eq("seg_addr", 32'(seg_addr), 32'(c - SNAKE_BASE));
      if (!hold) start = (c == pulse_at);
      @(posedge clk);
      #1;
      if (c < len) begin
        check_eq("plot", 32'(plot), 32'd1);
        check_eq("x", 32'(x), 32'(exp_x[c]));
        check_eq("y", 32'(y), 32'(exp_y[c]));
        check_eq("colour", 32'(colour), 32'(exp_c[c]));
        check_eq("done_early", 32'(done), 32'd0);
        check_eq("busy_mid", 32'(busy), 32'd1);
      end else begin
        check_eq("plot_in_done", 32'(plot), 32'd0);
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_in_done", 32'(busy), 32'd1);
      end
    end
    @(posedge clk);
    #1;
    check_eq("plot_after_done", 32'(plot), 32'd0);
    check_eq("done_single", 32'(done), 32'd0);
    check_eq("busy_after_done", 32'(busy), 32'(hold));
  endtask

  initial begin
    int sz;
    reset      = 1'b1;
    start      = 1'b0;
    snake_size = 8'd0;
    apple_x    = 8'd0;
    apple_y    = 7'd0;
    for (int i = 0; i < 128; i++) begin
      seg_mem_x[i] = 8'($urandom_range(0, 255));
      seg_mem_y[i] = 7'($urandom_range(0, 127));
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_plot", 32'(plot), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_x", 32'(x), 32'd0);
    check_eq("rst_y", 32'(y), 32'd0);
    check_eq("rst_colour", 32'(colour), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Frame 1: three segments, fixed apple, stray start pulse mid-clear
    snake_size = 8'd3;
    apple_x    = 8'd50;
    apple_y    = 7'd40;
    build_expected(3, 50, 40);
    launch(1'b0);
    check_frame(1'b0, $urandom_range(100, 19000));

    // Frame 2: no snake, start held high the whole time
    snake_size = 8'd0;
    apple_x    = 8'($urandom_range(0, 255));
    apple_y    = 7'($urandom_range(0, 127));
    build_expected(0, int'(apple_x), int'(apple_y));
    launch(1'b1);
    check_frame(1'b1, -1);

    // Frame 3 was accepted from IDLE by the held start: oversized snake
    start      = 1'b0;
    snake_size = 8'd200;
    build_expected(200, int'(apple_x), int'(apple_y));
    check_frame(1'b0, -1);

    // Reset in the middle of the clear pass
    sz         = $urandom_range(0, 255);
    snake_size = 8'(sz);
    apple_x    = 8'($urandom_range(0, 255));
    apple_y    = 7'($urandom_range(0, 127));
    launch(1'b0);
    repeat (5000) @(posedge clk);
    #1;
    check_eq("mid_x", 32'(x), 32'(4999 % W));
    check_eq("mid_y", 32'(y), 32'(4999 / W));
    check_eq("mid_plot", 32'(plot), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("mrst_plot", 32'(plot), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_x", 32'(x), 32'd0);
    check_eq("mrst_y", 32'(y), 32'd0);
    check_eq("mrst_colour", 32'(colour), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);

    // Fresh full frame after the reset
    build_expected(sz, int'(apple_x), int'(apple_y));
    launch(1'b0);
    check_frame(1'b0, $urandom_range(100, 19000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
